// File: rtl/elevator_scheduler.sv
// Single-car SCAN elevator: latches floor calls, times travel and door dwell.
// One edge from a visible call to a decision; call_req is never stalled (no backpressure).
module elevator_scheduler #(
  parameter int N_FLOORS      = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic                arrive,
  output logic [N_FLOORS-1:0] pending
);
  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t             state;
  logic [CNT_W-1:0]   timer;
  logic [FLOOR_W-1:0] arr_floor;
  logic [1:0]         sel_cur;
  logic [1:0]         sel_arr;
  logic [N_FLOORS-1:0] set_mask;
  logic [N_FLOORS-1:0] clr_mask;

  // Returns {go, up}: SCAN keeps the preferred direction while calls remain ahead.
  function automatic logic [1:0] select_dir(input logic [FLOOR_W-1:0] floor,
                                            input logic up,
                                            input logic [N_FLOORS-1:0] pend);
    logic above;
    logic below;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(floor)) above = above | pend[i];
      if (i < int'(floor)) below = below | pend[i];
    end
    if (up) select_dir = above ? 2'b11 : (below ? 2'b10 : {1'b0, up});
    else    select_dir = below ? 2'b10 : (above ? 2'b11 : {1'b0, up});
  endfunction

  assign arr_floor = dir_up ? cur_floor + 1'b1 : cur_floor - 1'b1;
  assign sel_cur   = select_dir(cur_floor, dir_up, pending);
  assign sel_arr   = select_dir(arr_floor, dir_up, pending);

  // A call at the open-door floor is absorbed by the door reload instead of latching.
  always_comb begin
    set_mask = call_req;
    if (state == DOOR) set_mask[cur_floor] = 1'b0;
  end

  always_comb begin
    clr_mask = '0;
    if (state == IDLE && pending[cur_floor]) clr_mask[cur_floor] = 1'b1;
    if (state == MOVE && timer == TRAVEL_LAST && pending[arr_floor]) clr_mask[arr_floor] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      cur_floor <= '0;
      dir_up    <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
      pending   <= '0;
    end else begin
      arrive  <= 1'b0;
      pending <= (pending | set_mask) & ~clr_mask;
      case (state)
        IDLE: begin
          timer <= '0;
          if (pending[cur_floor]) begin
            state     <= DOOR;
            door_open <= 1'b1;
          end else if (sel_cur[1]) begin
            state  <= MOVE;
            moving <= 1'b1;
            dir_up <= sel_cur[0];
          end
        end
        MOVE: begin
          if (timer == TRAVEL_LAST) begin
            cur_floor <= arr_floor;
            arrive    <= 1'b1;
            timer     <= '0;
            if (pending[arr_floor]) begin
              state     <= DOOR;
              moving    <= 1'b0;
              door_open <= 1'b1;
            end else if (sel_arr[1]) begin
              dir_up <= sel_arr[0];
            end else begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DOOR: begin
          if (call_req[cur_floor]) begin
            timer <= '0;
          end else if (timer == DOOR_LAST) begin
            state     <= IDLE;
            door_open <= 1'b0;
            timer     <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          timer     <= '0;
          moving    <= 1'b0;
          door_open <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random calls, checked by an event scoreboard.
module tb_elevator_scheduler;
  localparam int N  = 4;
  localparam int FW = 2;
  localparam int TC = 8;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  call_req = '0;
  logic [FW-1:0] cur_floor;
  logic          dir_up;
  logic          moving;
  logic          door_open;
  logic          arrive;
  logic [N-1:0]  pending;

  elevator_scheduler #(.N_FLOORS(N), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .cur_floor(cur_floor), .dir_up(dir_up),
    .moving(moving), .door_open(door_open), .arrive(arrive), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 1 arrive, 2 door opens, 3 door closes
    int stamp;
    int floor;
    int pend;
    int up;
    int mv;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  started = 0;
  bit  mon_prev_door = 0;

  // Reference model: remaining-cycle counters, not a state machine.
  int       m_floor = 0;
  bit       m_up = 1;
  int       m_travel = 0;
  int       m_door = 0;
  bit [N-1:0] m_pend = '0;

  // Directed-scenario observations
  int  door_cycles = 0;
  bit  moving_seen = 0;
  bit  arrive_seen = 0;
  bit  stim_prev_door = 0;
  int  door_floors[$];

  function automatic int pick_dir(input int fl, input bit up, input bit [N-1:0] p);
    bit above = 0;
    bit below = 0;
    for (int i = 0; i < N; i++) begin
      if (p[i] && i > fl) above = 1;
      if (p[i] && i < fl) below = 1;
    end
    if (up) return above ? 1 : (below ? 0 : -1);
    return below ? 0 : (above ? 1 : -1);
  endfunction

  task automatic push_ev(input int kind);
    ev_t e;
    e.kind = kind; e.stamp = cyc + 1; e.floor = m_floor; e.pend = int'(m_pend);
    e.up = int'(m_up); e.mv = (m_travel > 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit [N-1:0] c, input bit r);
    bit ev_arr = 0, ev_open = 0, ev_close = 0, decide = 0;
    bit [N-1:0] old_p = m_pend;
    bit [N-1:0] c2 = c;
    int d;
    if (r) begin
      if (m_door > 0) ev_close = 1;
      m_floor = 0; m_up = 1; m_travel = 0; m_door = 0; m_pend = '0;
    end else if (m_door > 0) begin
      c2[m_floor] = 0;
      m_pend |= c2;
      if (c[m_floor]) m_door = DC;
      else begin
        m_door--;
        if (m_door == 0) ev_close = 1;
      end
    end else begin
      m_pend |= c;
      if (m_travel > 0) begin
        m_travel--;
        if (m_travel == 0) begin
          m_floor += m_up ? 1 : -1;
          ev_arr = 1;
          decide = 1;
        end
      end else decide = 1;
      if (decide) begin
        if (old_p[m_floor]) begin
          m_pend[m_floor] = 0;
          m_door = DC;
          ev_open = 1;
        end else begin
          d = pick_dir(m_floor, m_up, old_p);
          if (d >= 0) begin
            m_up = (d == 1);
            m_travel = TC;
          end
        end
      end
    end
    if (ev_arr) push_ev(1);
    if (ev_open) push_ev(2);
    if (ev_close) push_ev(3);
  endtask

  task automatic tick(input bit [N-1:0] c, input bit r);
    call_req = c;
    reset = r;
    model_step(c, r);
    @(posedge clk);
    #1;
    cyc++;
    if (door_open === 1'b1) door_cycles++;
    if (moving === 1'b1) moving_seen = 1;
    if (arrive === 1'b1) arrive_seen = 1;
    if (door_open === 1'b1 && !stim_prev_door) door_floors.push_back(int'(cur_floor));
    stim_prev_door = (door_open === 1'b1);
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic clear_obs();
    door_cycles = 0; moving_seen = 0; arrive_seen = 0; door_floors.delete();
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while (!(m_travel == 0 && m_door == 0 && m_pend == 0) && n < budget) begin
      tick('0, 0);
      n++;
    end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL idle_timeout: still busy after %0d cycles", budget);
    end
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d floor %0d, none expected", kind, cyc, cur_floor);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.stamp != cyc || e.floor != int'(cur_floor) || e.pend != int'(pending)
        || e.up != int'(dir_up) || e.mv != int'(moving)) begin
      fails++;
      $display("FAIL event kind/cycle/floor/pend/up/mv: got %0d/%0d/%0d/%0h/%0d/%0d expected %0d/%0d/%0d/%0h/%0d/%0d",
               kind, cyc, cur_floor, pending, dir_up, moving, e.kind, e.stamp, e.floor, e.pend, e.up, e.mv);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows an arrival or a door edge.
  always @(negedge clk) begin
    if (started) begin
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
        tests++; fails++;
        $display("FAIL missed_event: kind %0d floor %0d due cycle %0d, not seen by cycle %0d",
                 exp_q[0].kind, exp_q[0].floor, exp_q[0].stamp, cyc);
        void'(exp_q.pop_front());
      end
      if (arrive === 1'b1) check_ev(1);
      if (door_open === 1'b1 && !mon_prev_door) check_ev(2);
      if (door_open !== 1'b1 && mon_prev_door) check_ev(3);
      mon_prev_door = (door_open === 1'b1);
    end
  end

  initial begin
    int n;
    bit [N-1:0] c;
    bit r;
    #1;
    // Reset held two cycles with all calls asserted
    tick('1, 1);
    started = 1;
    tick('1, 1);
    chk("rst_floor", int'(cur_floor), 0);
    chk("rst_dir_up", int'(dir_up), 1);
    chk("rst_moving", int'(moving), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_arrive", int'(arrive), 0);
    chk("rst_pending", int'(pending), 0);
    tick('0, 0);
    chk("post_rst_pending", int'(pending), 0);

    // Idle at 0, call floor 2
    clear_obs();
    tick(4'b0100, 0);
    chk("latch_pending", int'(pending), 4'b0100);
    tick('0, 0);
    chk("move_starts", int'(moving), 1);
    run_idle(200);
    chk("a_floor", int'(cur_floor), 2);
    chk("a_door_cycles", door_cycles, 10);
    chk("a_pending", int'(pending), 0);

    // Moving up 1->2 with calls at 3 and 0: serve 3 then reverse to 0
    tick('0, 1);
    clear_obs();
    tick(4'b1000, 0);
    n = 0;
    while (!(m_floor == 1 && m_travel > 0) && n < 100) begin tick('0, 0); n++; end
    tick(4'b0001, 0);
    chk("b_pending", int'(pending), 4'b1001);
    run_idle(300);
    chk("b_door_count", door_floors.size(), 2);
    if (door_floors.size() == 2) begin
      chk("b_first_stop", door_floors[0], 3);
      chk("b_second_stop", door_floors[1], 0);
    end
    chk("b_final_dir", int'(dir_up), 0);

    // Door reload at floor 2 on door cycle 5
    tick('0, 1);
    tick(4'b0100, 0);
    n = 0;
    while (m_door == 0 && n < 100) begin tick('0, 0); n++; end
    clear_obs();
    door_cycles = 1;
    n = 0;
    while (m_door != 6 && n < 20) begin tick('0, 0); n++; end
    tick(4'b0100, 0);
    chk("c_no_latch", int'(pending[2]), 0);
    run_idle(100);
    chk("c_door_cycles", door_cycles, 15);

    // Call at current floor while idle
    clear_obs();
    tick(4'b0100, 0);
    tick('0, 0);
    chk("d_door_next", int'(door_open), 1);
    run_idle(100);
    chk("d_no_move", int'(moving_seen), 0);
    chk("d_no_arrive", int'(arrive_seen), 0);

    // Reset in the middle of a move
    tick('0, 1);
    tick(4'b1000, 0);
    n = 0;
    while (!(m_floor == 1 && m_travel > 0) && n < 100) begin tick('0, 0); n++; end
    chk("e_pre_floor", int'(cur_floor), 1);
    chk("e_pre_pending", int'(pending), 4'b1000);
    tick('0, 1);
    chk("e_floor", int'(cur_floor), 0);
    chk("e_moving", int'(moving), 0);
    chk("e_pending", int'(pending), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 499) == 0);
      c = ($urandom_range(0, 9) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
      tick(c, r);
    end
    run_idle(500);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
